cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter: DIV, default 4, period of cpu_ce in RUN, in clk cycles; legal range 2..65535.
REQ-002 Parameter: ADDR_W, default 6, width of the data-memory inspect address.
REQ-003 Port: clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: run_sw  in  1  run switch level; a rising edge requests RUN, low requests HALT.
REQ-006 Port: step_btn  in  1  debounced level; a rising edge requests a single CPU cycle.
REQ-007 Port: left_btn / right_btn  in  1 each  debounced levels; a rising edge decrements / increments the inspect address.
REQ-008 Port: halt_req  in  1  CPU halt request, level.
REQ-009 Port: mode_sw  in  1  1 selects the stepped address, 0 selects sw_addr.
REQ-010 Port: sw_addr  in  ADDR_W  address taken from switches.
REQ-011 Port: cpu_ce  out  1  registered CPU clock-enable pulse, one clk wide.
REQ-012 Port: dm_addr  out  ADDR_W  registered data-memory address to the CPU debug port.
REQ-013 Port: state  out  2  current state: HALT=0, RUN=1, STEP=2.
REQ-014 Port: cyc_cnt  out  16  count of issued cpu_ce pulses.

Function
REQ-015 Edge detect: each of run_sw, step_btn, left_btn and right_btn has a prev register; edge = level & ~prev.
REQ-016 FSM HALT -> RUN on a run_sw edge, only when halt_req=0; with halt_req=1 the FSM stays in HALT.
REQ-017 FSM HALT -> STEP on a step_btn edge; if run_sw and step_btn edges coincide, RUN wins.
REQ-018 STEP lasts exactly one cycle: cpu_ce=1 in the following cycle, then the FSM returns to HALT.
REQ-019 FSM RUN -> HALT when run_sw=0 or halt_req=1, evaluated every cycle; this has priority over cpu_ce generation.
REQ-020 Divider counter is cleared on RUN entry and counts 0..DIV-1 while in RUN; cpu_ce=1 in the cycle after the count equals DIV-1.
REQ-021 First cpu_ce arrives DIV cycles after the cycle state=RUN is first visible.
REQ-022 If a halt condition coincides with a terminal count, no cpu_ce is issued.
REQ-023 step_btn edges in RUN or STEP are ignored, not queued.
REQ-024 Step address: a right edge gives +1 and a left edge gives -1, modulo 2^ADDR_W.
REQ-025 Wrap-around: max+1 -> 0 and 0-1 -> max.
REQ-026 Simultaneous left and right edges leave the address unchanged.
REQ-027 dm_addr <= mode_sw ? step_addr : sw_addr, with one-cycle latency; a step-address update is visible on dm_addr two cycles after the edge.
REQ-028 Address logic operates in all FSM states.
REQ-029 cpu_ce is never high in two consecutive cycles when DIV >= 2.

Reset
REQ-030 With rst=1 at a clk edge: state=HALT, divider=0, cpu_ce=0, step address=0, dm_addr=0, cyc_cnt=0.
REQ-031 All prev registers reset to 1, so buttons or switches held high through reset produce no edge.
REQ-032 Reset asserted mid-RUN or mid-STEP suppresses any pending cpu_ce in that cycle.

Configuration
REQ-033 Macro CPU_RUN_CTRL_CYCLE_COUNT_EN defined: cyc_cnt increments by 1 for each cpu_ce pulse and saturates at 16'hFFFF.
REQ-034 Macro not defined: cyc_cnt is tied to 0 and no counter register is synthesised; all other behaviour is identical.

Verification
REQ-035 Reset, then run_sw 0->1 with DIV=4: state=1 next cycle; cpu_ce pulses at +5, +9, +13 cycles after the run_sw edge.
REQ-036 In HALT, step_btn 0->1 held for 50 cycles: exactly one cpu_ce pulse; state goes 0 -> 2 -> 0; with the macro, cyc_cnt=1.
REQ-037 In RUN, halt_req=1 on a terminal-count cycle: no cpu_ce, state=0; a run_sw re-edge while halt_req=1 keeps state=0.
REQ-038 mode_sw=1 with address 0: one left edge gives dm_addr=63; two right edges then give dm_addr=1; left and right edges in the same cycle leave dm_addr=1.
REQ-039 mode_sw=0 with sw_addr=6'h2A: dm_addr=6'h2A one cycle later; switching mode_sw to 1 gives the step address.
REQ-040 Hold rst=1 with all buttons high, then release: no address change and state=0. With the macro and 70000 RUN pulses, cyc_cnt=16'hFFFF.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for a debug CPU: divided clock-enable generation and a stepped data-memory inspect address.
// Optional cpu_ce pulse counter enabled by defining CPU_RUN_CTRL_CYCLE_COUNT_EN.
module cpu_run_ctrl #(
    parameter int DIV    = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_sw,
    input  logic              step_btn,
    input  logic              left_btn,
    input  logic              right_btn,
    input  logic              halt_req,
    input  logic              mode_sw,
    input  logic [ADDR_W-1:0] sw_addr,
    output logic              cpu_ce,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [1:0]        state,
    output logic [15:0]       cyc_cnt
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t            cur_state, nxt_state;
    logic [15:0]       div_cnt, nxt_div_cnt;
    logic              nxt_ce;
    logic              run_prev, step_prev, left_prev, right_prev;
    logic              run_edge, step_edge, left_edge, right_edge;
    logic [ADDR_W-1:0] step_addr;

    assign run_edge   = run_sw & ~run_prev;
    assign step_edge  = step_btn & ~step_prev;
    assign left_edge  = left_btn & ~left_prev;
    assign right_edge = right_btn & ~right_prev;

    always_comb begin
        nxt_state   = cur_state;
        nxt_div_cnt = div_cnt;
        nxt_ce      = 1'b0;
        unique case (cur_state)
            S_HALT: begin
                if (run_edge && !halt_req) begin
                    nxt_state   = S_RUN;
                    nxt_div_cnt = 16'd0;
                end else if (step_edge) begin
                    nxt_state = S_STEP;
                end
            end
            S_RUN: begin
                // Halt check outranks the terminal count so a late halt drops the pending pulse.
                if (!run_sw || halt_req) begin
                    nxt_state   = S_HALT;
                    nxt_div_cnt = 16'd0;
                end else if (div_cnt == DIV_LAST) begin
                    nxt_ce      = 1'b1;
                    nxt_div_cnt = 16'd0;
                end else begin
                    nxt_div_cnt = div_cnt + 16'd1;
                end
            end
            S_STEP: begin
                nxt_ce    = 1'b1;
                nxt_state = S_HALT;
            end
            default: nxt_state = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= S_HALT;
            div_cnt    <= 16'd0;
            cpu_ce     <= 1'b0;
            run_prev   <= 1'b1;
            step_prev  <= 1'b1;
            left_prev  <= 1'b1;
            right_prev <= 1'b1;
            step_addr  <= '0;
            dm_addr    <= '0;
        end else begin
            cur_state  <= nxt_state;
            div_cnt    <= nxt_div_cnt;
            cpu_ce     <= nxt_ce;
            run_prev   <= run_sw;
            step_prev  <= step_btn;
            left_prev  <= left_btn;
            right_prev <= right_btn;
            // Coincident left and right edges cancel out.
            if (right_edge && !left_edge) begin
                step_addr <= step_addr + 1'b1;
            end else if (left_edge && !right_edge) begin
                step_addr <= step_addr - 1'b1;
            end
            dm_addr <= mode_sw ? step_addr : sw_addr;
        end
    end

    assign state = cur_state;

`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 16'd0;
        end else if (nxt_ce && cyc_q != 16'hFFFF) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign cyc_cnt = cyc_q;
`else
    assign cyc_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl (DIV=4, ADDR_W=6).
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw, step_btn, left_btn, right_btn, halt_req, mode_sw;
    logic [5:0]  sw_addr;
    logic        cpu_ce;
    logic [5:0]  dm_addr;
    logic [1:0]  state;
    logic [15:0] cyc_cnt;

    int total = 0;
    int bad   = 0;
    int ce_seen;

    cpu_run_ctrl #(.DIV(4), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
        .left_btn(left_btn), .right_btn(right_btn), .halt_req(halt_req),
        .mode_sw(mode_sw), .sw_addr(sw_addr), .cpu_ce(cpu_ce),
        .dm_addr(dm_addr), .state(state), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; run_sw = 0; step_btn = 0; left_btn = 0; right_btn = 0;
        halt_req = 0; mode_sw = 0; sw_addr = 6'h00;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_state", 32'(state), 32'd0);
        check("reset_ce", 32'(cpu_ce), 32'd0);
        check("reset_dm", 32'(dm_addr), 32'd0);
        check("reset_cyc", 32'(cyc_cnt), 32'd0);

        // Run: pulses at +5, +9, +13 after the run_sw edge.
        run_sw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            if (k == 1) check("run_state", 32'(state), 32'd1);
            check($sformatf("run_ce_k%0d", k), 32'(cpu_ce),
                  32'((k == 5) || (k == 9) || (k == 13)));
        end

        // Halt on the terminal-count cycle drops the pulse.
        tick(2);
        halt_req = 1'b1;
        tick(1);
        check("halt_tc_ce", 32'(cpu_ce), 32'd0);
        check("halt_tc_state", 32'(state), 32'd0);
        tick(1);
        check("halt_tc_ce2", 32'(cpu_ce), 32'd0);
        run_sw = 1'b0;
        tick(1);
        run_sw = 1'b1;
        tick(1);
        check("rerun_blocked1", 32'(state), 32'd0);
        tick(1);
        check("rerun_blocked2", 32'(state), 32'd0);
        halt_req = 1'b0;
        run_sw = 1'b0;
        tick(1);

        // Single step with step_btn held for 50 cycles.
        step_btn = 1'b1;
        ce_seen = 0;
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            if (cpu_ce) ce_seen++;
            if (k == 1) check("step_state_k1", 32'(state), 32'd2);
            if (k == 2) begin
                check("step_state_k2", 32'(state), 32'd0);
                check("step_ce_k2", 32'(cpu_ce), 32'd1);
            end
        end
        check("step_pulses", 32'(ce_seen), 32'd1);
        check("step_end_state", 32'(state), 32'd0);
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
        check("cyc_after_step", 32'(cyc_cnt), 32'd4);
`else
        check("cyc_tied", 32'(cyc_cnt), 32'd0);
`endif
        step_btn = 1'b0;
        tick(1);

        // Stepped address with wrap-around.
        mode_sw = 1'b1;
        tick(1);
        left_btn = 1'b1;
        tick(1);
        check("addr_latency", 32'(dm_addr), 32'd0);
        tick(1);
        check("addr_left_wrap", 32'(dm_addr), 32'd63);
        left_btn = 1'b0;
        right_btn = 1'b1; tick(1);
        right_btn = 1'b0; tick(1);
        right_btn = 1'b1; tick(1);
        right_btn = 1'b0; tick(1);
        tick(1);
        check("addr_right_wrap", 32'(dm_addr), 32'd1);
        left_btn = 1'b1; right_btn = 1'b1;
        tick(2);
        check("addr_both", 32'(dm_addr), 32'd1);
        left_btn = 1'b0; right_btn = 1'b0;
        tick(1);

        // Switch-sourced address and mode change.
        mode_sw = 1'b0;
        sw_addr = 6'h2A;
        tick(1);
        check("sw_addr", 32'(dm_addr), 32'h2A);
        mode_sw = 1'b1;
        tick(1);
        check("mode_back", 32'(dm_addr), 32'd1);

        // Reset with everything held high: no edges afterwards.
        run_sw = 1'b1; step_btn = 1'b1; left_btn = 1'b1; right_btn = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        check("held_state", 32'(state), 32'd0);
        check("held_dm", 32'(dm_addr), 32'd0);
        check("held_ce", 32'(cpu_ce), 32'd0);
        check("held_cyc", 32'(cyc_cnt), 32'd0);

        // Reset on a terminal-count cycle suppresses the pulse.
        step_btn = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
        run_sw = 1'b0;
        tick(1);
        run_sw = 1'b1;
        tick(1);
        check("rerun_state", 32'(state), 32'd1);
        tick(3);
        rst = 1'b1;
        tick(1);
        check("rst_mid_run_ce", 32'(cpu_ce), 32'd0);
        check("rst_mid_run_state", 32'(state), 32'd0);
        rst = 1'b0;
        run_sw = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
